// File: rtl/sigmoid_pkg.sv
// Shared constants and types for the sigmoid datapath.
// Used by the denormalizer (denorm_shift) and by the normalization
// block that produces the shift count, so both agree on widths and range.
package sigmoid_pkg;

  // Default quotient and shift-count widths
  localparam int DATA_W_DEF  = 16;
  localparam int SHIFT_W_DEF = 4;

  // Normalized denominator range: after a one-bit shift the denominator
  // sits in [NORM_LO, NORM_HI), i.e. a Q1.13 value in [1.0, 2.0).
  localparam int NORM_FRAC_BITS = 13;
  localparam int NORM_LO        = 1 << NORM_FRAC_BITS;        // 8192
  localparam int NORM_HI        = 1 << (NORM_FRAC_BITS + 1);  // 16384

  // Denormalizer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } denorm_state_t;

endpackage

// File: rtl/denorm_shift.sv
// Post-divide denormalizer: undoes the range-normalization shift on a
// CORDIC quotient, one bit per clock. Right shifts round half-up on the
// last bit shifted out; left shifts flag any 1 bit lost past the MSB.
// Build option DENORM_SATURATE_EN: when defined, a left-shift overflow
// forces the result to all ones; otherwise the wrapped value is output.
module denorm_shift
  import sigmoid_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_left,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_ovf
);

  denorm_state_t state, state_nxt;

  logic [DATA_W-1:0]  work;
  logic [SHIFT_W-1:0] count;
  logic               guard;
  logic               ovf;
  logic               left;
  logic               accept;
  logic [DATA_W-1:0]  result;

  // Right-shift rounding: add back the last bit shifted out. The MSB is
  // already 0 after any shift of one or more, so this cannot carry out.
  function automatic logic [DATA_W-1:0] round_half_up(
    input logic [DATA_W-1:0] val,
    input logic              g
  );
    return val + {{(DATA_W-1){1'b0}}, g};
  endfunction

  // Left-shift overflow handling: clamp to all ones or keep the wrap.
  function automatic logic [DATA_W-1:0] saturate(
    input logic [DATA_W-1:0] val,
    input logic              o
  );
`ifdef DENORM_SATURATE_EN
    return o ? {DATA_W{1'b1}} : val;
`else
    return o ? val : val;
`endif
  endfunction

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) state_nxt = (in_shift == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == {{(SHIFT_W-1){1'b0}}, 1'b1}) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working register: capture on accept, then one shift step per SHIFT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= '0;
      count <= '0;
      guard <= 1'b0;
      ovf   <= 1'b0;
      left  <= 1'b0;
    end else if (accept) begin
      work  <= in_data;
      count <= in_shift;
      left  <= in_left;
      guard <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == SHIFT) begin
      count <= count - 1'b1;
      if (left) begin
        work <= {work[DATA_W-2:0], 1'b0};
        ovf  <= ovf | work[DATA_W-1];
      end else begin
        work  <= {1'b0, work[DATA_W-1:1]};
        guard <= work[0];
      end
    end
  end

  // Result selection; outputs read zero outside DONE so nothing stale leaks
  always_comb begin
    result   = left ? saturate(work, ovf) : round_half_up(work, guard);
    out_data = (state == DONE) ? result : '0;
    out_ovf  = (state == DONE) & left & ovf;
  end

endmodule

// File: tb/tb_denorm_shift.sv
// Directed and randomized checks for denorm_shift against an arithmetic
// reference of the shift/round/overflow rules.
module tb_denorm_shift;

  localparam int DATA_W  = 16;
  localparam int SHIFT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHIFT_W-1:0] in_shift;
  logic               in_left;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_ovf;

  int errors = 0;
  int checks = 0;

  denorm_shift #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_left   (in_left),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: arithmetic definition of the denormalized result
  task automatic model(input logic [15:0] d, input int s, input logic lft,
                       output logic [15:0] q, output logic o);
    longint full;
    if (lft) begin
      full = longint'(d) << s;
      o    = (full >> DATA_W) != 0;
      q    = full[15:0];
`ifdef DENORM_SATURATE_EN
      if (o) q = 16'hFFFF;
`endif
    end else begin
      o = 1'b0;
      if (s == 0) q = d;
      else        q = 16'((int'(d) >> s) + ((int'(d) >> (s - 1)) & 1));
    end
  endtask

  // One transaction: accept, measure latency, optional backpressure, handshake
  task automatic run(input string tag, input logic [15:0] d, input int s,
                     input logic lft, input int bp);
    logic [15:0] eq;
    logic        eo;
    int          lat;
    int          w;
    model(d, s, lft, eq, eo);
    out_ready = (bp == 0);
    w = 0;
    while (!in_ready && w < 50) begin cyc(); w++; end
    check({tag, " ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = SHIFT_W'(s);
    in_left  = lft;
    cyc();
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) begin
        check({tag, " busy_ready"}, in_ready, 0);
      end
      cyc();
      lat++;
    end
    check({tag, " latency"}, lat, s + 1);
    check({tag, " data"}, out_data, eq);
    check({tag, " ovf"}, out_ovf, eo);
    for (int i = 0; i < bp; i++) begin
      cyc();
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_data"}, out_data, eq);
      check({tag, " hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    cyc();
    check({tag, " after_valid"}, out_valid, 0);
    check({tag, " after_ready"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_left   = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_ovf", out_ovf, 0);
    rst = 1'b0;
    cyc();
    check("idle in_ready", in_ready, 1);

    run("r0", 16'hABCD, 0, 1'b0, 0);
    run("r1", 16'h3001, 1, 1'b0, 0);
    run("r15", 16'hFFFF, 15, 1'b0, 0);
    run("l2ovf", 16'h4000, 2, 1'b1, 0);
    run("bp", 16'h0010, 3, 1'b1, 5);
    run("l0", 16'h8001, 0, 1'b1, 0);
    run("l15", 16'h0001, 15, 1'b1, 1);

    // Reset in the middle of a long right shift
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    in_shift  = 4'd8;
    in_left   = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("mid_rst out_valid", out_valid, 0);
    check("mid_rst out_data", out_data, 0);
    check("mid_rst out_ovf", out_ovf, 0);
    check("mid_rst in_ready", in_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst in_ready", in_ready, 1);
    check("post_rst out_valid", out_valid, 0);
    check("post_rst out_data", out_data, 0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("post_rst no_output", out_valid, 0);
    end
    run("post_rst txn", 16'h00FF, 4, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run("rand", 16'($urandom), int'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
